btn_condition: RTL

Input-conditioning stage that sits directly upstream of the game top level. It takes the six raw board push-buttons (four movement, fire, start), synchronises and debounces them in the `clk_65M` domain, and emits clean levels, single-cycle press pulses and auto-repeat pulses. The shooter logic consumes these instead of the `clk_200h`-sampled pulse path, which removes the slow divided clocks from the control path.

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_debounce.sv | 111 +++++++++++
 rtl/btn_condition.sv | 80 ++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioning stage.
package btn_pkg;

   localparam int unsigned NUM_BTN   = 6;

   localparam int unsigned BTN_LEFT  = 0;
   localparam int unsigned BTN_RIGHT = 1;
   localparam int unsigned BTN_UP    = 2;
   localparam int unsigned BTN_DOWN  = 3;
   localparam int unsigned BTN_FIRE  = 4;
   localparam int unsigned BTN_START = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } rpt_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, tick-based debounce, rising-edge press
// pulse and the auto-repeat state machine.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int unsigned DB_TICKS  = 10,
   parameter int unsigned RPT_DELAY = 300,
   parameter int unsigned RPT_RATE  = 50,
   parameter bit          RPT_EN    = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   input  logic tick,
   output logic level,
   output logic press,
   output logic level_c,
   output logic rpt_c
);

   localparam int unsigned DB_W    = $clog2(DB_TICKS + 1);
   localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
   localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

   logic [1:0]      sync_q;
   logic            sync;
   logic [DB_W-1:0] db_cnt, db_cnt_d;
   logic            level_d;
   logic            rise;
   rpt_state_t      state, state_d;
   logic [RPT_W-1:0] rpt_cnt, rpt_cnt_d;

   assign sync = sync_q[1];
   assign rise = level & ~level_d;

   // Accept the synchronised value on the DB_TICKS-th consecutive tick it differs.
   always_comb begin
      db_cnt_d = db_cnt;
      level_c  = level;
      if (sync == level) begin
         db_cnt_d = '0;
      end else if (tick) begin
         if (db_cnt >= DB_W'(DB_TICKS - 1)) begin
            level_c  = sync;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt + DB_W'(1);
         end
      end
   end

   // Repeat FSM; a falling level wins over a repeat due in the same cycle.
   always_comb begin
      state_d   = state;
      rpt_cnt_d = rpt_cnt;
      rpt_c     = rise;
      if (RPT_EN) begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state_d   = HOLD;
                  rpt_cnt_d = '0;
               end
            end
            HOLD: begin
               if (!level) begin
                  state_d = IDLE;
               end else if (rpt_cnt >= RPT_W'(RPT_DELAY)) begin
                  rpt_c     = 1'b1;
                  rpt_cnt_d = '0;
                  state_d   = REPEAT;
               end else if (tick) begin
                  rpt_cnt_d = rpt_cnt + RPT_W'(1);
               end
            end
            REPEAT: begin
               if (!level) begin
                  state_d = IDLE;
               end else if (rpt_cnt >= RPT_W'(RPT_RATE)) begin
                  rpt_c     = 1'b1;
                  rpt_cnt_d = '0;
               end else if (tick) begin
                  rpt_cnt_d = rpt_cnt + RPT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         db_cnt  <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
         press   <= 1'b0;
         state   <= IDLE;
         rpt_cnt <= '0;
      end else begin
         sync_q  <= {sync_q[0], btn_raw};
         db_cnt  <= db_cnt_d;
         level   <= level_c;
         level_d <= level;
         press   <= rise;
         state   <= state_d;
         rpt_cnt <= rpt_cnt_d;
      end
   end

endmodule

// File: rtl/btn_condition.sv
// Board push-button conditioning: shared tick prescaler, six debounce lanes
// and opposing-direction repeat suppression.
module btn_condition
   import btn_pkg::*;
#(
   parameter int unsigned         TICK_DIV    = 65000,
   parameter int unsigned         DB_TICKS    = 10,
   parameter int unsigned         RPT_DELAY   = 300,
   parameter int unsigned         RPT_RATE    = 50,
   parameter logic [NUM_BTN-1:0]  REPEAT_MASK = 6'b001111
) (
   input  logic               clk_65M,
   input  logic               clear_n,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_rpt,
   output logic               tick
);

   localparam int unsigned PRE_W = $clog2(TICK_DIV + 1);

   logic [PRE_W-1:0]   pre_cnt, pre_cnt_d;
   logic [NUM_BTN-1:0] level_c;
   logic [NUM_BTN-1:0] rpt_c;
   logic [NUM_BTN-1:0] rpt_allow;

   always_comb begin
      pre_cnt_d = pre_cnt + PRE_W'(1);
      if (pre_cnt >= PRE_W'(TICK_DIV - 1)) pre_cnt_d = '0;
   end

   // tick is registered so it is high exactly while the count sits at TICK_DIV-1.
   always_ff @(posedge clk_65M or negedge clear_n) begin
      if (!clear_n) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         pre_cnt <= pre_cnt_d;
         tick    <= (pre_cnt_d == PRE_W'(TICK_DIV - 1));
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DB_TICKS  (DB_TICKS),
         .RPT_DELAY (RPT_DELAY),
         .RPT_RATE  (RPT_RATE),
         .RPT_EN    (REPEAT_MASK[i])
      ) u_db (
         .clk     (clk_65M),
         .rst_n   (clear_n),
         .btn_raw (btn_in[i]),
         .tick    (tick),
         .level   (btn_level[i]),
         .press   (btn_press[i]),
         .level_c (level_c[i]),
         .rpt_c   (rpt_c[i])
      );
   end

   // Judged on next-cycle levels so the gate lines up with the registered pulse.
   always_comb begin
      rpt_allow = '1;
      if (level_c[BTN_LEFT] && level_c[BTN_RIGHT]) begin
         rpt_allow[BTN_LEFT]  = 1'b0;
         rpt_allow[BTN_RIGHT] = 1'b0;
      end
      if (level_c[BTN_UP] && level_c[BTN_DOWN]) begin
         rpt_allow[BTN_UP]   = 1'b0;
         rpt_allow[BTN_DOWN] = 1'b0;
      end
   end

   always_ff @(posedge clk_65M or negedge clear_n) begin
      if (!clear_n) btn_rpt <= '0;
      else          btn_rpt <= rpt_c & rpt_allow;
   end

endmodule
